// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_fetch_unit_pkg : shared fetch-stage constants and state enum     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package if_fetch_unit_pkg;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam int          C_ADDR_W   = 30;
  localparam logic [31:0] C_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH      = 2'd0,
    ST_MISS       = 2'd1,
    ST_FLUSH_MISS = 2'd2,
    ST_HOLD       = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_hold_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_hold_buffer : 1-entry skid register for {valid, inst, pc+4}     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module if_hold_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic        i_invalidate,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc_plus_4,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc_plus_4
);

  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    if (i_clear) begin
      valid_d = 1'b0;
      inst_d  = C_NOP;
      pc4_d   = 32'h0;
    end else if (i_load) begin
      valid_d = 1'b1;
      inst_d  = i_inst;
      pc4_d   = i_pc_plus_4;
    end else if (i_invalidate) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= C_NOP;
      pc4_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_inst      = inst_q;
  assign o_pc_plus_4 = pc4_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_fetch_unit : PC owner and icache handshake feeding IF/ID        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter int          ADDR_W   = C_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              icache_read,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic [31:0]       icache_rdata,
  input  logic              icache_stall,
  input  logic              id_stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [31:0]       inst_out,
  output logic [31:0]       pc_plus_4_out,
  output logic              fetch_stall
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;

  logic [31:0]  w_pc_plus_4;
  logic [31:0]  w_branch_pc;
  logic         w_unused;
  logic         w_read, w_stall;
  logic [31:0]  w_inst, w_pc4;
  logic         w_hold_load, w_hold_clear, w_hold_inval;
  logic         w_hold_valid;
  logic [31:0]  w_hold_inst, w_hold_pc4;

  assign w_pc_plus_4 = pc_q + 32'd4;
  assign w_branch_pc = {branch_target[31:2], 2'b00};
  assign w_unused    = ^branch_target[1:0];

  if_hold_buffer u_hold (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_hold_load),
    .i_clear      (w_hold_clear),
    .i_invalidate (w_hold_inval),
    .i_inst       (icache_rdata),
    .i_pc_plus_4  (w_pc_plus_4),
    .o_valid      (w_hold_valid),
    .o_inst       (w_hold_inst),
    .o_pc_plus_4  (w_hold_pc4)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    w_read       = 1'b1;
    w_stall      = 1'b0;
    w_inst       = C_NOP;
    w_pc4        = 32'h0;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;
    w_hold_inval = 1'b0;
    case (state_q)
      ST_FETCH, ST_MISS: begin
        w_stall = icache_stall;
        if (branch_taken) begin
          // A redirect during an outstanding miss must wait for the cache
          if (state_q == ST_MISS) begin
            target_d = w_branch_pc;
            state_d  = ST_FLUSH_MISS;
          end else begin
            pc_d         = w_branch_pc;
            w_hold_clear = 1'b1;
          end
        end else if (icache_stall) begin
          state_d = ST_MISS;
        end else begin
          pc_d    = w_pc_plus_4;
          state_d = ST_FETCH;
          if (id_stall) begin
            w_hold_load = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            w_inst = icache_rdata;
            w_pc4  = w_pc_plus_4;
          end
        end
      end
      ST_FLUSH_MISS: begin
        w_stall = icache_stall;
        if (branch_taken) begin
          target_d = w_branch_pc;
        end
        if (!icache_stall) begin
          pc_d    = branch_taken ? w_branch_pc : target_q;
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        w_read = 1'b0;
        if (branch_taken) begin
          pc_d         = w_branch_pc;
          w_hold_clear = 1'b1;
          state_d      = ST_FETCH;
        end else begin
          w_inst = w_hold_valid ? w_hold_inst : C_NOP;
          w_pc4  = w_hold_valid ? w_hold_pc4 : 32'h0;
          if (!id_stall) begin
            w_hold_inval = 1'b1;
            state_d      = ST_FETCH;
          end
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  assign icache_addr   = pc_q[ADDR_W+1:2];
  assign icache_read   = rst ? 1'b0 : w_read;
  assign inst_out      = rst ? C_NOP : w_inst;
  assign pc_plus_4_out = rst ? 32'h0 : w_pc4;
  assign fetch_stall   = rst ? 1'b0 : w_stall;

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the IF/ID pipeline register inputs: the instruction word and PC+4 for each fetched instruction.
- Owns the PC register and the read handshake to the instruction cache.
- Absorbs decode-stage stalls and branch redirects, including redirects that arrive while a cache miss is outstanding.
- Raises a pipeline-freeze request while a miss is pending.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 30, icache word-address width (byte PC[31:2])

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
icache_read  out  1  fetch request to instruction cache
icache_addr  out  ADDR_W  word address, equals PC[31:2] of the in-flight fetch
icache_rdata  in  32  instruction word, valid when icache_read=1 and icache_stall=0
icache_stall  in  1  cache not ready for current address
id_stall  in  1  load-use stall from hazard unit; IF/ID holds, PC must not advance
branch_taken  in  1  redirect request from ID (branch/jump resolved)
branch_target  in  32  byte address of redirect, bits[1:0] ignored
inst_out  out  32  instruction to IF/ID INST_RegIN
pc_plus_4_out  out  32  PC+4 of inst_out, to IF/ID PC_plus_4IN
fetch_stall  out  1  freeze request to all pipeline registers during a miss

Behaviour:
- Reset is synchronous and active-high. On rst: PC=RESET_PC, state=FETCH, redirect register cleared, hold buffer cleared. While rst is high, icache_read=0, inst_out=0, pc_plus_4_out=0 and fetch_stall=0.
- icache_read=1 in FETCH, MISS and FLUSH_MISS.
- icache_addr=PC[31:2] and must stay stable while icache_stall=1, because the cache requires this.
- inst_out defaults to 32'h0 (NOP) whenever no valid instruction is presented.
- FETCH:
  - Hit (icache_stall=0), id_stall=0, branch_taken=0: present the instruction with 0-cycle latency (inst_out=icache_rdata, pc_plus_4_out=PC+4); PC<=PC+4.
  - Hit with id_stall=1, branch_taken=0: latch the instruction and PC+4 into the hold buffer, PC<=PC+4, go to HOLD.
  - icache_stall=1: fetch_stall=1, go to MISS.
- MISS:
  - fetch_stall=1 while icache_stall=1.
  - On ready: present the instruction, PC<=PC+4, return to FETCH. If id_stall=1 on that cycle, buffer it and go to HOLD instead.
- FLUSH_MISS (redirect pending during a miss):
  - fetch_stall=1 until icache_stall=0.
  - Returned data is discarded: inst_out=0.
  - PC<=saved target, go to FETCH.
- HOLD:
  - icache_read=0; inst_out and pc_plus_4_out come from the hold buffer.
  - When id_stall=0, the buffered instruction is consumed that cycle and the state returns to FETCH.
- branch_taken (IF/ID flushes itself; this block only redirects):
  - In FETCH or HOLD: PC<={branch_target[31:2],2'b00}, hold buffer invalidated, go to FETCH, inst_out=0 that cycle.
  - In MISS: save the target, go to FLUSH_MISS.
  - In FLUSH_MISS: overwrite the saved target (the newest redirect wins).
- Simultaneous branch_taken and id_stall: branch_taken wins; the PC is redirected and the stall is ignored for PC update.
- PC arithmetic is 32-bit modulo. PC=32'hFFFF_FFFC wraps to 0; pc_plus_4_out=0 at wrap.
- fetch_stall is combinational from state and icache_stall, with no register stage.

Decomposition:
- Shared pipeline package: state encoding (FETCH, MISS, FLUSH_MISS, HOLD as a 2-bit enum), NOP constant 32'h0, RESET_PC default, ADDR_W.
- One natural sub-module: if_hold_buffer, a 1-entry skid register holding {valid, inst, pc_plus_4} with load/clear/invalidate. Everything else stays in one file.

Test Plan:
1. Reset, then the cache hits every cycle for 4 cycles -> icache_addr 0,1,2,3; pc_plus_4_out 4,8,12,16; fetch_stall=0 throughout.
2. Miss for 3 cycles at PC=0x20 (icache_stall=1) -> fetch_stall=1 for exactly 3 cycles, icache_addr stable at 0x8; rdata 0x8C010000 is presented on the ready cycle with pc_plus_4_out=0x24.
3. branch_taken with target 0x100 on cycle 2 of a 4-cycle miss at PC=0x40 -> data returned at ready is dropped (inst_out=0); next icache_addr=0x40 (word), i.e. PC=0x100; a second redirect to 0x200 during the same miss wins.
4. id_stall high for 2 cycles during a hit at PC=0x10 -> HOLD entered with inst held, icache_read=0, the instruction is presented once when id_stall drops, next fetch at PC=0x14.
5. branch_taken and id_stall both high, target 0x300 -> next icache_addr=0xC0, hold buffer empty, inst_out=0 that cycle.
6. Reset asserted mid-miss with PC=0x80 -> next cycle PC=RESET_PC, state FETCH, fetch_stall=0, saved redirect cleared; PC=0xFFFFFFFC hit -> next PC=0.
